// File: rtl/mips_check_pkg.sv
// Shared types and constants for the MIPS self-checking instruction sequencer.
package mips_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0000;

    localparam int unsigned DEFAULT_DEPTH   = 16;
    localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mips_check_sequencer_if.sv
// Instruction/result handshake between the check sequencer (master) and the core (slave).
interface mips_check_sequencer_if #(
    parameter int unsigned DATA_W = 32
) ();

    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_valid;

    modport master (
        output instr_out,
        output instr_valid,
        input  instr_ready,
        input  res_data,
        input  res_valid
    );

    modport slave (
        input  instr_out,
        input  instr_valid,
        output instr_ready,
        output res_data,
        output res_valid
    );

endinterface

// File: rtl/mips_check_mem.sv
// Program store: one instruction/expected-result pair per entry, one write port and
// one asynchronous read port. Contents are not reset.
module mips_check_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata_instr,
    input  logic [DATA_W-1:0] wdata_expect,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_instr,
    output logic [DATA_W-1:0] rdata_expect
);

    logic [2*DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= {wdata_instr, wdata_expect};
        end
    end

    assign {rdata_instr, rdata_expect} = mem[raddr];

endmodule

// File: rtl/mips_check_sequencer.sv
// Handshaked instruction sequencer: issues a stored program to the core, scores each
// returned result against its expected value and reports pass/fail/timeout status.
module mips_check_sequencer
    import mips_check_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W  = $clog2(DEPTH),
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  prog_we,
    input  logic [ADDR_W-1:0]     prog_addr,
    input  logic [DATA_W-1:0]     prog_instr,
    input  logic [DATA_W-1:0]     prog_expect,
    input  logic [ADDR_W:0]       prog_len,
    input  logic                  start,
    input  logic                  abort,
    mips_check_sequencer_if.master core,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       pass_cnt,
    output logic [ADDR_W:0]       fail_cnt,
    output logic [ADDR_W-1:0]     first_fail,
    output logic                  timeout_seen
);

    localparam int unsigned CW = ADDR_W + 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CW-1:0]     len_q, len_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] instr_out_q, instr_out_d;
    logic              instr_valid_q, instr_valid_d;
    logic [DATA_W-1:0] expect_q, expect_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CW-1:0]     pass_q, pass_d;
    logic [CW-1:0]     fail_q, fail_d;
    logic [ADDR_W-1:0] first_fail_q, first_fail_d;
    logic              tmo_seen_q, tmo_seen_d;

    logic [ADDR_W-1:0] rd_idx;
    logic [DATA_W-1:0] rd_instr, rd_expect;
    logic [CW-1:0]     len_in;

    // Read the entry that the next ISSUE will present, so instr_out can be registered.
    assign rd_idx = (state_q == WAIT) ? idx_q + ADDR_W'(1) : '0;
    assign len_in = (prog_len > DEPTH_C) ? DEPTH_C : prog_len;

    mips_check_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk          (clk),
        .we           (prog_we && !busy_q),
        .waddr        (prog_addr),
        .wdata_instr  (prog_instr),
        .wdata_expect (prog_expect),
        .raddr        (rd_idx),
        .rdata_instr  (rd_instr),
        .rdata_expect (rd_expect)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        timer_d       = timer_q;
        instr_out_d   = instr_out_q;
        instr_valid_d = instr_valid_q;
        expect_d      = expect_q;
        busy_d        = busy_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        first_fail_d  = first_fail_q;
        tmo_seen_d    = tmo_seen_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pass_d       = '0;
                    fail_d       = '0;
                    first_fail_d = '0;
                    tmo_seen_d   = 1'b0;
                    idx_d        = '0;
                    timer_d      = '0;
                    len_d        = len_in;
                    if (len_in == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d       = ISSUE;
                        done_d        = 1'b0;
                        busy_d        = 1'b1;
                        instr_valid_d = 1'b1;
                        instr_out_d   = rd_instr;
                        expect_d      = rd_expect;
                    end
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_d       = IDLE;
                    busy_d        = 1'b0;
                    instr_valid_d = 1'b0;
                    instr_out_d   = DATA_W'(NOP);
                end else if (core.instr_ready) begin
                    state_d       = WAIT;
                    timer_d       = '0;
                    instr_valid_d = 1'b0;
                    instr_out_d   = DATA_W'(NOP);
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    timer_d = '0;
                end else if (core.res_valid || timer_q == TMO_LAST) begin
                    // A result arriving on the timeout cycle is scored as a result.
                    if (core.res_valid && core.res_data == expect_q) begin
                        if (pass_q != '1) pass_d = pass_q + CW'(1);
                    end else begin
                        if (fail_q != '1) fail_d = fail_q + CW'(1);
                        if (fail_q == '0) first_fail_d = idx_q;
                        if (!core.res_valid) tmo_seen_d = 1'b1;
                    end
                    timer_d = '0;
                    if ({1'b0, idx_q} == len_q - CW'(1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d       = ISSUE;
                        idx_d         = rd_idx;
                        instr_valid_d = 1'b1;
                        instr_out_d   = rd_instr;
                        expect_d      = rd_expect;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            len_q         <= '0;
            timer_q       <= '0;
            instr_out_q   <= '0;
            instr_valid_q <= 1'b0;
            expect_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= '0;
            fail_q        <= '0;
            first_fail_q  <= '0;
            tmo_seen_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            timer_q       <= timer_d;
            instr_out_q   <= instr_out_d;
            instr_valid_q <= instr_valid_d;
            expect_q      <= expect_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            first_fail_q  <= first_fail_d;
            tmo_seen_q    <= tmo_seen_d;
        end
    end

    assign core.instr_out   = instr_out_q;
    assign core.instr_valid = instr_valid_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass_cnt         = pass_q;
    assign fail_cnt         = fail_q;
    assign first_fail       = first_fail_q;
    assign timeout_seen     = tmo_seen_q;

endmodule

// File: tb/tb_mips_check_sequencer.sv
// Scoreboard bench for mips_check_sequencer: stimulus pushes expected issues and run
// summaries; a monitor pops and compares them when the DUT presents them.
module tb_mips_check_sequencer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    typedef struct {
        int p;
        int f;
        int ff;
        int to;
    } run_t;

    logic              clk;
    logic              rst_n;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_instr;
    logic [DATA_W-1:0] prog_expect;
    logic [ADDR_W:0]   prog_len;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   pass_cnt;
    logic [ADDR_W:0]   fail_cnt;
    logic [ADDR_W-1:0] first_fail;
    logic              timeout_seen;

    mips_check_sequencer_if #(.DATA_W(DATA_W)) bus ();

    mips_check_sequencer #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_instr   (prog_instr),
        .prog_expect  (prog_expect),
        .prog_len     (prog_len),
        .start        (start),
        .abort        (abort),
        .core         (bus),
        .busy         (busy),
        .done         (done),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt),
        .first_fail   (first_fail),
        .timeout_seen (timeout_seen)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_instr_q[$];
    run_t        exp_run_q[$];
    logic        done_prev;

    // Bench copy of legally written program contents and per-entry core behaviour.
    logic [31:0] p_instr [DEPTH];
    logic [31:0] p_exp   [DEPTH];
    logic [31:0] res_word[DEPTH];
    int          rdy_wait[DEPTH];
    int          res_lat [DEPTH];
    int          gap     [DEPTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.instr_valid && bus.instr_ready) begin
                if (exp_instr_q.size() == 0) chk("unexpected_issue", 32'(bus.instr_valid), 0);
                else chk("instr_out", bus.instr_out, exp_instr_q.pop_front());
            end
            if (done && !done_prev) begin
                if (exp_run_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 0);
                end else begin
                    run_t r;
                    r = exp_run_q.pop_front();
                    chk("pass_cnt", 32'(pass_cnt), 32'(r.p));
                    chk("fail_cnt", 32'(fail_cnt), 32'(r.f));
                    chk("first_fail", 32'(first_fail), 32'(r.ff));
                    chk("timeout_seen", 32'(timeout_seen), 32'(r.to));
                    chk("busy_at_done", 32'(busy), 0);
                end
            end
        end
        done_prev <= rst_n ? done : 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] ins, input logic [31:0] ex);
        prog_we = 1'b1;
        prog_addr = ADDR_W'(a);
        prog_instr = ins;
        prog_expect = ex;
        tick();
        prog_we = 1'b0;
        p_instr[a] = ins;
        p_exp[a] = ex;
    endtask

    task automatic core_ok();
        for (int i = 0; i < DEPTH; i++) begin
            res_word[i] = p_exp[i];
            rdy_wait[i] = 0;
            res_lat[i] = 0;
            gap[i] = -1;
        end
    endtask

    task automatic push_run(input int p, input int f, input int ff, input int to);
        run_t r;
        r.p = p;
        r.f = f;
        r.ff = ff;
        r.to = to;
        exp_run_q.push_back(r);
    endtask

    task automatic start_run(input int len, input int npush);
        for (int i = 0; i < npush; i++) exp_instr_q.push_back(p_instr[i]);
        prog_len = (ADDR_W + 1)'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic serve(input int n);
        for (int e = 0; e < n; e++) begin
            int g = 0;
            while (!bus.instr_valid && g < 60) begin
                tick();
                g++;
            end
            gap[e] = g;
            if (!bus.instr_valid) begin
                chk("issue_wait", 32'(bus.instr_valid), 1);
                return;
            end
            for (int s = 0; s < rdy_wait[e]; s++) begin
                chk("stall_valid", 32'(bus.instr_valid), 1);
                chk("stall_instr", bus.instr_out, p_instr[e]);
                tick();
            end
            bus.instr_ready = 1'b1;
            tick();
            bus.instr_ready = 1'b0;
            if (res_lat[e] >= 0) begin
                repeat (res_lat[e]) tick();
                bus.res_valid = 1'b1;
                bus.res_data = res_word[e];
                tick();
                bus.res_valid = 1'b0;
                bus.res_data = '0;
            end
        end
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 100) begin
            tick();
            g++;
        end
        if (!done) chk("done_wait", 32'(done), 1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 0);
        chk({tag, "_instr_out"}, bus.instr_out, 0);
        chk({tag, "_pass_cnt"}, 32'(pass_cnt), 0);
        chk({tag, "_fail_cnt"}, 32'(fail_cnt), 0);
        chk({tag, "_first_fail"}, 32'(first_fail), 0);
        chk({tag, "_timeout_seen"}, 32'(timeout_seen), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        prog_we = 1'b0;
        prog_addr = '0;
        prog_instr = '0;
        prog_expect = '0;
        prog_len = '0;
        start = 1'b0;
        abort = 1'b0;
        bus.instr_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data = '0;
        repeat (3) tick();
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        load(0, 32'h0000_08C0, 32'h0);
        load(1, 32'h0022_1820, 32'h0);
        load(2, 32'h3001_0000, 32'h0);

        // All three entries match, result one cycle after accept.
        core_ok();
        push_run(3, 0, 0, 0);
        start_run(3, 3);
        chk("start_busy", 32'(busy), 1);
        chk("start_valid", 32'(bus.instr_valid), 1);
        serve(3);
        chk("back_to_back_gap", 32'(gap[1]), 0);
        wait_done();

        // Entry 1 returns a wrong value.
        core_ok();
        res_word[1] = 32'h1;
        push_run(2, 1, 1, 0);
        start_run(3, 3);
        serve(3);
        wait_done();

        // Entry 0 never answers: scored exactly 15 cycles into WAIT.
        core_ok();
        res_lat[0] = -1;
        push_run(2, 1, 0, 1);
        start_run(3, 3);
        serve(3);
        chk("timeout_gap", 32'(gap[1]), 15);
        wait_done();

        // Ready held low 5 cycles; result lands on the timeout cycle and still wins.
        core_ok();
        rdy_wait[0] = 5;
        res_lat[0] = 14;
        push_run(3, 0, 0, 0);
        start_run(3, 3);
        serve(3);
        wait_done();

        // A write while busy must be dropped.
        core_ok();
        push_run(3, 0, 0, 0);
        start_run(3, 3);
        prog_we = 1'b1;
        prog_addr = 4'd1;
        prog_instr = 32'hDEAD_BEEF;
        prog_expect = 32'h1234_5678;
        tick();
        prog_we = 1'b0;
        serve(3);
        wait_done();

        // Fill the program; prog_len above DEPTH clamps to DEPTH.
        for (int i = 3; i < DEPTH; i++) load(i, 32'h2000_0000 | 32'(i), 32'h100 * 32'(i));
        core_ok();
        push_run(16, 0, 0, 0);
        start_run(31, 16);
        serve(16);
        wait_done();

        // Abort in WAIT of entry 2 of 4: counters kept, done stays low.
        core_ok();
        start_run(4, 3);
        serve(2);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_valid", 32'(bus.instr_valid), 0);
        chk("abort_pass", 32'(pass_cnt), 2);
        chk("abort_fail", 32'(fail_cnt), 0);

        // Zero-length run completes in one cycle with cleared counters.
        push_run(0, 0, 0, 0);
        start_run(0, 0);
        chk("len0_done", 32'(done), 1);
        chk("len0_busy", 32'(busy), 0);
        tick();

        // Reset mid-run with a handshake pending.
        core_ok();
        res_word[1] = 32'h0000_BEEF;
        start_run(3, 2);
        serve(2);
        chk("pre_reset_valid", 32'(bus.instr_valid), 1);
        chk("pre_reset_pass", 32'(pass_cnt), 1);
        chk("pre_reset_fail", 32'(fail_cnt), 1);
        chk("pre_reset_first_fail", 32'(first_fail), 1);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrun_reset");
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_after_reset_valid", 32'(bus.instr_valid), 0);

        chk("instr_queue_drained", 32'(exp_instr_q.size()), 0);
        chk("run_queue_drained", 32'(exp_run_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_check_sequencer.md
# mips_check_sequencer

Synthesizable self-checking instruction sequencer for the MIPS core. It holds a loadable program of up to DEPTH instruction/expected-result pairs and issues them to the core one at a time over a valid/ready handshake. It compares each returned result and keeps pass/fail counters, the first failing index and a timeout flag. It sits between the bench (or a host loader) and `mips_core`, and replaces fixed-delay instruction stimulus with a handshaked, parametrised checker.

## Interface
- DATA_W, 32, instruction and result width
- DEPTH, 16, program entries (power of two, ≥2)
- ADDR_W, $clog2(DEPTH), index width
- TIMEOUT, 15, cycles waited for a result before it is scored as a failure (≥1)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- prog_we  in  1  program write strobe
- prog_addr  in  ADDR_W  program write index
- prog_instr  in  DATA_W  instruction to store
- prog_expect  in  DATA_W  expected core result for that entry
- prog_len  in  ADDR_W+1  entries to run (0..DEPTH), sampled on start
- start  in  1  begin a run
- abort  in  1  terminate a run
- instr_out  out  DATA_W  instruction presented to the core
- instr_valid  out  1  instr_out is valid
- instr_ready  in  1  core accepts instr_out
- res_data  in  DATA_W  core result
- res_valid  in  1  res_data is valid
- busy  out  1  run in progress
- done  out  1  run completed; held until next start
- pass_cnt  out  ADDR_W+1  matched entries
- fail_cnt  out  ADDR_W+1  mismatched or timed-out entries
- first_fail  out  ADDR_W  index of the first failure; valid when fail_cnt≠0
- timeout_seen  out  1  at least one entry timed out in this run

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - start with latched length >0 → ISSUE. Clears pass_cnt, fail_cnt, first_fail, timeout_seen and done; sets idx=0.
  - start with prog_len=0 → DONE, with counters cleared.
  - prog_len >DEPTH is clamped to DEPTH.
- **ISSUE**
  - instr_valid=1, instr_out=mem_instr[idx].
  - On instr_valid&&instr_ready → WAIT; timer=0.
- **WAIT**
  - instr_valid=0; timer increments each cycle.
  - res_valid: compare res_data with mem_expect[idx]. Equal → pass_cnt+1; else fail_cnt+1.
  - Timer reaching TIMEOUT-1 with no res_valid: fail_cnt+1 and timeout_seen=1.
  - res_valid and timeout in the same cycle: the result wins.
  - On the first failure of the run, first_fail=idx.
  - After scoring: idx==len-1 → DONE; otherwise idx+1 and → ISSUE.
- **DONE**
  - done=1, busy=0.
  - start → new run, same as from IDLE.
- **abort**
  - Honoured in ISSUE or WAIT → IDLE next cycle.
  - Counters and flags are retained; done stays 0.
- **start while busy:** ignored.
- **prog_we:** writes mem[prog_addr] only when busy=0; ignored while busy.
- **res_valid outside WAIT:** ignored, with no counter change.
- **Counters:** saturate at 2^(ADDR_W+1)-1 (not reachable for legal len, but required).

## Timing
- Reset values:
  - state=IDLE, idx=0, timer=0.
  - instr_valid=0, instr_out=0.
  - busy=0, done=0, pass_cnt=0, fail_cnt=0, first_fail=0, timeout_seen=0.
  - Program memory is not reset.
- All outputs are registered.
- busy=1 from the cycle after start until the cycle DONE is entered.
- instr_valid rises the cycle after start (or after the previous entry's score) and holds, with stable instr_out, until accepted.
- Minimum per-entry cost is 2 cycles: ISSUE accepted, then WAIT with res_valid in its first cycle.
- Counter update and the next ISSUE are visible the cycle after res_valid.
- Timeout is scored exactly TIMEOUT cycles after entering WAIT.
- Writes are visible to a run started the next cycle or later.
- Reset asserted mid-run: immediate return to reset values; any pending handshake is dropped.

## Structure
- Package `mips_check_pkg`:
  - state enum (IDLE/ISSUE/WAIT/DONE)
  - NOP constant 32'h0000_0000
  - default DEPTH/TIMEOUT localparams
- Sub-module `mips_check_mem`: DEPTH×(2·DATA_W) register array, one write port, one async read port indexed by idx.
- The FSM, timer and counters live in the top module.

## Test plan
- Load 3 entries: (0x000008C0 sll, exp 0), (0x00221820 add, exp 0), (0x30010000 andi, exp 0). Core model returns 0 one cycle after accept, prog_len=3 → pass_cnt=3, fail_cnt=0, done=1, timeout_seen=0.
- Same program, core returns 0x1 for entry 1 → pass_cnt=2, fail_cnt=1, first_fail=1.
- Core never asserts res_valid for entry 0, TIMEOUT=15 → entry scored at cycle 15 of WAIT; fail_cnt=1, timeout_seen=1, run continues to entry 1.
- instr_ready held low 5 cycles → instr_valid and instr_out stable for all 5 cycles; no timer progress.
- abort during WAIT of entry 2 of 4, then rst_n low mid-run → IDLE, done=0, counters retained after abort; all outputs return to zero on reset.
- prog_len=0 start → DONE in 1 cycle with zero counters. prog_we while busy → memory unchanged, verified on the next run.
